// File: rtl/priority_encoder_seq.sv
// priority_encoder_seq: sticky request register feeding a two-state grant FSM.
// Define PRIORITY_ENCODER_RR_EN for round-robin arbitration; default is fixed priority (d[7] highest).
module priority_encoder_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [7:0] d,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       valid,
  output logic [7:0] pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] code;
  logic       accept;
  logic [7:0] clear_mask;
  logic [7:0] pending_next;
  logic [2:0] search_start;
  logic [2:0] probe;
  logic [2:0] sel_idx;
  logic       sel_found;

  // A request arriving in the same cycle its index is accepted survives the clear.
  assign accept       = (state == PRESENT) && ready;
  assign clear_mask   = accept ? (8'b1 << code) : 8'h00;
  assign pending_next = (pending & ~clear_mask) | (d & {8{e}});

`ifdef PRIORITY_ENCODER_RR_EN
  logic [2:0] last_ptr;

  // The last accepted index becomes the lowest priority for the next search.
  assign search_start = last_ptr - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr <= 3'd0;
    end else if (accept) begin
      last_ptr <= code;
    end
  end
`else
  assign search_start = 3'd7;
`endif

  // Descending search from search_start, wrapping 0 -> 7, first set bit wins.
  always_comb begin
    sel_idx   = 3'd0;
    sel_found = 1'b0;
    probe     = 3'd0;
    for (int k = 0; k < 8; k++) begin
      probe = search_start - 3'(k);
      if (!sel_found && pending[probe]) begin
        sel_idx   = probe;
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid   <= 1'b0;
      code    <= 3'd0;
      pending <= 8'h00;
    end else begin
      pending <= pending_next;
      case (state)
        IDLE: begin
          if (sel_found) begin
            code  <= sel_idx;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign a = code[2];
  assign b = code[1];
  assign c = code[0];

endmodule
